// File: rtl/timer_device.sv
// rtl/timer_device.sv - memory-mapped countdown timer with IRQ; optional prescaler via TIMER_PRESCALER_EN
module timer_device
`ifdef TIMER_PRESCALER_EN
#(
    parameter int unsigned PRESCALE = 4
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        select,
    input  logic        writeEnable,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        irq,
    input  logic [31:0] debugPC
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pend_q, pend_d;
    logic        tick;
    logic        wr;

    assign wr = select && writeEnable;

`ifdef TIMER_PRESCALER_EN
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
    logic [15:0] pre_q, pre_d;
`endif

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;
        tick     = 1'b1;
`ifdef TIMER_PRESCALER_EN
        pre_d    = 16'd0;
        if (state_q == CNT && ctrl_q[0]) begin
            tick  = (pre_q == PRE_LAST);
            pre_d = tick ? 16'd0 : pre_q + 16'd1;
        end
`endif
        case (state_q)
            IDLE: if (ctrl_q[0]) state_d = LOAD;
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (count_q == 32'd0) begin
                        state_d = INT;
                        pend_d  = 1'b1;
                    end else begin
                        count_d = count_q - 32'd1;
                    end
                end
            end
            INT: begin
                if (ctrl_q[2:1] == 2'b01) begin
                    state_d = LOAD;
                    pend_d  = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // CPU stores are applied last so they win over FSM updates; masking (IM=0) acknowledges
        if (wr) begin
            case (address[3:2])
                A_CTRL: begin
                    ctrl_d = writeData[3:0];
                    if (!writeData[3]) pend_d = 1'b0;
                end
                A_PRESET: begin
                    preset_d = writeData;
                    pend_d   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            pend_q   <= 1'b0;
`ifdef TIMER_PRESCALER_EN
            pre_q    <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
`ifdef TIMER_PRESCALER_EN
            pre_q    <= pre_d;
`endif
        end
    end

    always_comb begin
        readData = 32'd0;
        case (address[3:2])
            A_CTRL:   readData = {28'd0, ctrl_q};
            A_PRESET: readData = preset_q;
            A_COUNT:  readData = count_q;
            default:  readData = 32'd0;
        endcase
    end

    assign irq = ctrl_q[3] && pend_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && wr)
            $display("%d@%h: *%h <= %h", $time, debugPC, address, writeData);
    end
`endif
endmodule
